// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: successive-approximation control FSM for a 12-bit SAR ADC.
// Samples the input for SAMPLE_CYCLES clocks, then resolves one bit per
// clock from MSB to LSB and publishes the result with a one-cycle strobe.
module adc_sar_ctrl #(
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_in,
    input  logic        start_in,
    input  logic        comparator_in,
    output logic        sample_out,
    output logic [11:0] dac_out,
    output logic        busy_out,
    output logic [11:0] data_out,
    output logic        data_valid_strobe_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SAMPLE = 4'(SAMPLE_CYCLES - 1);
    localparam logic [3:0] MSB_INDEX   = 4'd11;

    state_t      state;
    state_t      next_state;
    logic [3:0]  sample_cnt;
    logic [3:0]  bit_idx;
    logic [11:0] partial;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the last bit decision hands over to SAMPLE or IDLE by enable_in.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable_in || start_in) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                if (sample_cnt == LAST_SAMPLE) begin
                    next_state = CONVERT;
                end
            end
            CONVERT: begin
                if (bit_idx == 4'd0) begin
                    next_state = enable_in ? SAMPLE : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Sample counter, bit index, partial result and the published result with its strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt            <= 4'd0;
            bit_idx               <= MSB_INDEX;
            partial               <= 12'd0;
            data_out              <= 12'd0;
            data_valid_strobe_out <= 1'b0;
        end else begin
            data_valid_strobe_out <= 1'b0;
            case (state)
                SAMPLE: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        sample_cnt <= 4'd0;
                        bit_idx    <= MSB_INDEX;
                        partial    <= 12'd0;
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
                CONVERT: begin
                    partial[bit_idx] <= comparator_in;
                    if (bit_idx == 4'd0) begin
                        data_out              <= {partial[11:1], comparator_in};
                        data_valid_strobe_out <= 1'b1;
                        bit_idx               <= MSB_INDEX;
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                    end
                end
                default: begin
                    sample_cnt <= 4'd0;
                    bit_idx    <= MSB_INDEX;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state; the trial code is the partial result plus the bit under test.
    always_comb begin
        sample_out = (state == SAMPLE);
        busy_out   = (state != IDLE);
        dac_out    = 12'd0;
        if (state == CONVERT) begin
            dac_out = partial | (12'd1 << bit_idx);
        end
    end

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// tb_adc_sar_ctrl: directed self-checking bench for adc_sar_ctrl with S = 2.
// The comparator is either an ideal model (vin_code >= dac_out) or tied to a constant.
module tb_adc_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in;
    logic        start_in;
    logic        comparator_in;
    logic        sample_out;
    logic [11:0] dac_out;
    logic        busy_out;
    logic [11:0] data_out;
    logic        data_valid_strobe_out;

    logic [11:0] vin_code;
    logic        use_tie;
    logic        tie_val;

    int errors = 0;
    int checks = 0;

    logic [11:0] dac_seen [12];
    logic [11:0] got_data;
    int          strobe_cyc;
    int          strobe_count;
    logic        busy_after;

    logic [11:0] exp_a5c [12] = '{12'h800, 12'hC00, 12'hA00, 12'hB00, 12'hA80, 12'hA40,
                                  12'hA60, 12'hA50, 12'hA58, 12'hA5C, 12'hA5E, 12'hA5D};
    logic [11:0] cont_vals [4] = '{12'h100, 12'h200, 12'h300, 12'h400};

    adc_sar_ctrl #(.SAMPLE_CYCLES(2)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable_in             (enable_in),
        .start_in              (start_in),
        .comparator_in         (comparator_in),
        .sample_out            (sample_out),
        .dac_out               (dac_out),
        .busy_out              (busy_out),
        .data_out              (data_out),
        .data_valid_strobe_out (data_valid_strobe_out)
    );

    always #5 clk = ~clk;

    assign comparator_in = use_tie ? tie_val : (vin_code >= dac_out);

    // One start-triggered conversion; records the trial codes, result, strobe timing and idle state afterwards.
    task automatic run_conversion();
        strobe_cyc   = 0;
        strobe_count = 0;
        got_data     = 12'h000;
        busy_after   = 1'b1;
        @(negedge clk);
        start_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_in = 1'b0;
            if (c >= 3 && c <= 14) dac_seen[c - 3] = dac_out;
            if (data_valid_strobe_out) begin
                strobe_count++;
                if (strobe_cyc == 0) begin
                    strobe_cyc = c;
                    got_data   = data_out;
                end
            end
            if (c == 16) busy_after = busy_out;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sample_out, dac_out, busy_out, data_out, data_valid_strobe_out} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got s=%b dac=%h busy=%b data=%h strobe=%b, expected all zero",
                     sample_out, dac_out, busy_out, data_out, data_valid_strobe_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || sample_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b sample=%b, expected 0 0", busy_out, sample_out);
        end
    endtask

    task automatic test_single_conversion();
        use_tie  = 1'b0;
        vin_code = 12'hA5C;
        run_conversion();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dac_seen[i] !== exp_a5c[i]) begin
                errors++;
                $display("[TB] FAIL a5c_dac_step%0d: got %h expected %h", i, dac_seen[i], exp_a5c[i]);
            end
        end
        checks++;
        if (got_data !== 12'hA5C) begin
            errors++;
            $display("[TB] FAIL a5c_data: got %h expected a5c", got_data);
        end
        checks++;
        if (strobe_cyc != 15 || strobe_count != 1) begin
            errors++;
            $display("[TB] FAIL a5c_strobe: got cycle %0d count %0d expected cycle 15 count 1",
                     strobe_cyc, strobe_count);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL a5c_busy_after: got %b expected 0", busy_after);
        end
    endtask

    task automatic test_comparator_ties();
        use_tie = 1'b1;
        tie_val = 1'b1;
        run_conversion();
        checks++;
        if (got_data !== 12'hFFF || dac_seen[11] !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL tie1: got data %h last dac %h expected fff fff", got_data, dac_seen[11]);
        end
        tie_val = 1'b0;
        run_conversion();
        checks++;
        if (got_data !== 12'h000 || strobe_cyc != 15) begin
            errors++;
            $display("[TB] FAIL tie0: got data %h cycle %0d expected 000 cycle 15", got_data, strobe_cyc);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dac_seen[i] !== (12'h800 >> i)) begin
                errors++;
                $display("[TB] FAIL tie0_dac_step%0d: got %h expected %h", i, dac_seen[i], 12'h800 >> i);
            end
        end
        use_tie = 1'b0;
    endtask

    task automatic test_continuous();
        int cyc;
        int idx;
        int last;
        int samples;
        cyc      = 0;
        idx      = 0;
        last     = 0;
        samples  = 0;
        vin_code = cont_vals[0];
        @(negedge clk);
        enable_in = 1'b1;
        while (idx < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (data_valid_strobe_out) begin
                checks++;
                if (data_out !== cont_vals[idx]) begin
                    errors++;
                    $display("[TB] FAIL cont_data%0d: got %h expected %h", idx, data_out, cont_vals[idx]);
                end
                checks++;
                if ((idx == 0 && cyc != 15) || (idx != 0 && cyc - last != 14)) begin
                    errors++;
                    $display("[TB] FAIL cont_period%0d: got cycle %0d (previous %0d) expected first 15 then +14",
                             idx, cyc, last);
                end
                checks++;
                if (samples != 2) begin
                    errors++;
                    $display("[TB] FAIL cont_samples%0d: got %0d expected 2", idx, samples);
                end
                samples = 0;
                last    = cyc;
                idx++;
                if (idx < 4) vin_code = cont_vals[idx];
            end
            if (sample_out) samples++;
        end
        enable_in = 1'b0;
        checks++;
        if (idx != 4) begin
            errors++;
            $display("[TB] FAIL cont_timeout: got %0d strobes expected 4", idx);
        end
        for (int c = 0; c < 30 && busy_out; c++) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_stop: got busy %b expected 0", busy_out);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_disable_mid();
        int strobes;
        int late_samples;
        strobes      = 0;
        late_samples = 0;
        vin_code     = 12'h5A5;
        @(negedge clk);
        enable_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checks++;
                if (dac_out !== 12'h5A0) begin
                    errors++;
                    $display("[TB] FAIL dis_bit5_dac: got %h expected 5a0", dac_out);
                end
                enable_in = 1'b0;
            end
            if (data_valid_strobe_out) begin
                strobes++;
                checks++;
                if (c != 15 || data_out !== 12'h5A5) begin
                    errors++;
                    $display("[TB] FAIL dis_strobe: got cycle %0d data %h expected cycle 15 data 5a5", c, data_out);
                end
            end
            if (c > 9 && sample_out) late_samples++;
            if (c == 16) begin
                checks++;
                if (busy_out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL dis_idle: got busy %b expected 0", busy_out);
                end
            end
        end
        checks++;
        if (strobes != 1 || late_samples != 0) begin
            errors++;
            $display("[TB] FAIL dis_counts: got strobes %0d late samples %0d expected 1 0", strobes, late_samples);
        end
    endtask

    task automatic test_back_to_back();
        int strobes;
        int samples;
        strobes  = 0;
        samples  = 0;
        vin_code = 12'h0F0;
        @(negedge clk);
        start_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_in = (c >= 3 && c <= 13) ? c[0] : 1'b0;
            if (sample_out) samples++;
            if (data_valid_strobe_out) begin
                strobes++;
                checks++;
                if (data_out !== 12'h0F0) begin
                    errors++;
                    $display("[TB] FAIL busy_start_data: got %h expected 0f0", data_out);
                end
            end
        end
        start_in = 1'b0;
        checks++;
        if (strobes != 1 || samples != 2 || busy_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_counts: got strobes %0d samples %0d busy %b expected 1 2 0",
                     strobes, samples, busy_out);
        end
    endtask

    task automatic test_reset_mid();
        int strobes;
        strobes  = 0;
        vin_code = 12'hFFF;
        @(negedge clk);
        start_in = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start_in = 1'b0;
            if (c == 6) rst_n = 1'b0;
            if (c == 7) begin
                rst_n = 1'b1;
                checks++;
                if ({sample_out, dac_out, busy_out, data_out, data_valid_strobe_out} !== 27'd0) begin
                    errors++;
                    $display("[TB] FAIL rstmid_outputs: got s=%b dac=%h busy=%b data=%h strobe=%b, expected all zero",
                             sample_out, dac_out, busy_out, data_out, data_valid_strobe_out);
                end
            end
            if (c > 6 && (data_valid_strobe_out || busy_out)) strobes++;
        end
        checks++;
        if (strobes != 0 || data_out !== 12'h000) begin
            errors++;
            $display("[TB] FAIL rstmid_quiet: got %0d active cycles data %h expected 0 000", strobes, data_out);
        end
        vin_code = 12'h3C7;
        run_conversion();
        checks++;
        if (got_data !== 12'h3C7 || strobe_cyc != 15) begin
            errors++;
            $display("[TB] FAIL rstmid_recover: got data %h cycle %0d expected 3c7 cycle 15", got_data, strobe_cyc);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable_in = 1'b0;
        start_in  = 1'b0;
        use_tie   = 1'b0;
        tie_val   = 1'b0;
        vin_code  = 12'h000;
        test_reset();
        test_single_conversion();
        test_comparator_ties();
        test_continuous();
        test_disable_mid();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
